// File: rtl/uart_defs.sv
// rtl/uart_defs.sv - shared UART state encodings, oversampling constants and vote helper
// Purpose: definitions shared by the oversampled receiver and, later, the transmitter.
// Ports: none (package).
package uart_defs;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK_WAIT
    } uart_state_e;

    localparam int OS_RATE = 16;
    localparam int SMP_LO  = 7;
    localparam int SMP_MID = 8;
    localparam int SMP_HI  = 9;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// rtl/uart_rx_os_if.sv - receiver result bundle towards the receive FIFO write side
// Purpose: groups the received word, its strobes and the busy flag.
// Ports: rx_dout (word), rx_done / frame_err / break_det (one-cycle pulses), rx_busy.
//        master = receiver (drives), slave = consumer (observes).
interface uart_rx_os_if #(
    parameter int nbits = 8
);
    logic [nbits-1:0] rx_dout;
    logic             rx_done;
    logic             frame_err;
    logic             break_det;
    logic             rx_busy;

    modport master (
        output rx_dout,
        output rx_done,
        output frame_err,
        output break_det,
        output rx_busy
    );

    modport slave (
        input rx_dout,
        input rx_done,
        input frame_err,
        input break_det,
        input rx_busy
    );
endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running oversample tick divider with phase clear
// Purpose: emits one tick every clk_div clocks; clr restarts the count at 0.
// Ports: clk, reset (async active-low), clr (restart phase), tick (one-cycle pulse).
module uart_baud_tick #(
    parameter int clk_div = 54
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int CW = (clk_div > 2) ? $clog2(clk_div) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(clk_div - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - 16x oversampling UART receiver with majority vote, framing and break detect
// Purpose: receives 1 start, nbits data (LSB first), stpbits stop frames, no parity.
// Ports: clk, reset (async active-low), rx (async serial line, idle high),
//        rx_if.master: rx_dout, rx_done, frame_err, break_det, rx_busy.
module uart_rx_os
    import uart_defs::*;
#(
    parameter int nbits   = 8,
    parameter int stpbits = 2,
    parameter int clk_div = 54
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rx,
    uart_rx_os_if.master   rx_if
);
    localparam logic [3:0] S_LO   = 4'(SMP_LO);
    localparam logic [3:0] S_MID  = 4'(SMP_MID);
    localparam logic [3:0] S_HI   = 4'(SMP_HI);
    localparam logic [3:0] S_LAST = 4'(OS_RATE - 1);
    localparam logic [3:0] N_DATA = 4'(nbits - 1);
    localparam logic [3:0] N_STOP = 4'(stpbits - 1);

    uart_state_e      state_q, state_d;
    logic             rx_meta_q, rx_s_q;
    logic [3:0]       s_cnt_q, s_cnt_d;
    logic [3:0]       n_q, n_d;
    logic [2:0]       smp_q, smp_d;
    logic [nbits-1:0] shift_q, shift_d;
    logic [nbits-1:0] dout_q, dout_d;
    logic             stop_bad_q, stop_bad_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;
    logic             brk_q, brk_d;
    logic             tick;
    logic             tick_clr;
    logic             maj_full;
    logic             maj_s9;

    uart_baud_tick #(
        .clk_div (clk_div)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .tick  (tick)
    );

    // Vote over stored samples 7/8/9, and the same vote at the s_cnt==9 tick
    // itself where the third sample is still the live synchronized input.
    assign maj_full = maj3(smp_q[0], smp_q[1], smp_q[2]);
    assign maj_s9   = maj3(smp_q[0], smp_q[1], rx_s_q);

    always_comb begin
        state_d    = state_q;
        s_cnt_d    = s_cnt_q;
        n_d        = n_q;
        smp_d      = smp_q;
        shift_d    = shift_q;
        dout_d     = dout_q;
        stop_bad_d = stop_bad_q;
        done_d     = 1'b0;
        ferr_d     = 1'b0;
        brk_d      = 1'b0;
        tick_clr   = 1'b0;

        if (tick && (state_q != IDLE) && (state_q != BRK_WAIT)) begin
            s_cnt_d = s_cnt_q + 4'd1;
            if (s_cnt_q == S_LO)  smp_d[0] = rx_s_q;
            if (s_cnt_q == S_MID) smp_d[1] = rx_s_q;
            if (s_cnt_q == S_HI)  smp_d[2] = rx_s_q;
        end

        case (state_q)
            IDLE: begin
                s_cnt_d    = '0;
                n_d        = '0;
                stop_bad_d = 1'b0;
                if (!rx_s_q) begin
                    state_d  = START;
                    tick_clr = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    // Early glitch reject: sample 9 is not taken yet, so two highs decide.
                    if ((s_cnt_q == S_MID) && smp_q[0] && rx_s_q) begin
                        state_d = IDLE;
                    end else if (s_cnt_q == S_LAST) begin
                        state_d = maj_full ? IDLE : DATA;
                        n_d     = '0;
                    end
                end
            end
            DATA: begin
                if (tick && (s_cnt_q == S_LAST)) begin
                    shift_d = {maj_full, shift_q[nbits-1:1]};
                    if (n_q == N_DATA) begin
                        state_d = STOP;
                        n_d     = '0;
                    end else begin
                        n_d = n_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick && (s_cnt_q == S_HI)) begin
                    if (n_q == N_STOP) begin
                        // Leave mid-bit so the next start edge is never missed.
                        if (stop_bad_q || !maj_s9) begin
                            if (shift_q == '0) begin
                                brk_d   = 1'b1;
                                state_d = BRK_WAIT;
                            end else begin
                                ferr_d  = 1'b1;
                                state_d = IDLE;
                            end
                        end else begin
                            dout_d  = shift_q;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        stop_bad_d = stop_bad_q | ~maj_s9;
                    end
                end else if (tick && (s_cnt_q == S_LAST)) begin
                    n_d = n_q + 4'd1;
                end
            end
            BRK_WAIT: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            s_cnt_q    <= '0;
            n_q        <= '0;
            smp_q      <= '0;
            shift_q    <= '0;
            dout_q     <= '0;
            stop_bad_q <= 1'b0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            s_cnt_q    <= s_cnt_d;
            n_q        <= n_d;
            smp_q      <= smp_d;
            shift_q    <= shift_d;
            dout_q     <= dout_d;
            stop_bad_q <= stop_bad_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
        end
    end

    assign rx_if.rx_dout   = dout_q;
    assign rx_if.rx_done   = done_q;
    assign rx_if.frame_err = ferr_q;
    assign rx_if.break_det = brk_q;
    assign rx_if.rx_busy   = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - directed self-checking bench for uart_rx_os
module tb_uart_rx_os;
    localparam int NB  = 8;
    localparam int SB  = 2;
    localparam int CD  = 4;
    localparam int BIT = 16 * CD;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic rx    = 1'b1;

    always #5 clk = ~clk;

    uart_rx_os_if #(.nbits(NB)) rx_if ();

    uart_rx_os #(
        .nbits   (NB),
        .stpbits (SB),
        .clk_div (CD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .rx_if (rx_if)
    );

    int vec_cnt  = 0;
    int err_cnt  = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int brk_cnt  = 0;
    int excl_cnt = 0;
    int wide_cnt = 0;
    int np;
    logic prev_pulse = 1'b0;
    logic [NB-1:0] got_q[$];

    always @(negedge clk) begin
        np = int'(rx_if.rx_done) + int'(rx_if.frame_err) + int'(rx_if.break_det);
        if (rx_if.rx_done) begin
            done_cnt++;
            got_q.push_back(rx_if.rx_dout);
        end
        if (rx_if.frame_err) ferr_cnt++;
        if (rx_if.break_det) brk_cnt++;
        if (np > 1) excl_cnt++;
        if ((np > 0) && prev_pulse) wide_cnt++;
        prev_pulse = (np > 0);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        wait_cyc(BIT);
    endtask

    // glitch=1 inverts each data bit for one tick around its s_cnt==8 sample.
    task automatic send_frame(input logic [NB-1:0] d, input logic s1, input logic s2, input logic glitch);
        send_bit(1'b0);
        for (int i = 0; i < NB; i++) begin
            if (!glitch) begin
                send_bit(d[i]);
            end else begin
                rx = d[i];
                wait_cyc(9 * CD);
                rx = ~d[i];
                wait_cyc(CD);
                rx = d[i];
                wait_cyc(BIT - 10 * CD);
            end
        end
        send_bit(s1);
        send_bit(s2);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        wait_cyc(3);
        vec_cnt++; if (rx_if.rx_dout !== 8'h00) begin err_cnt++; $display("FAIL reset_dout: got %h exp 00", rx_if.rx_dout); end
        vec_cnt++; if ({rx_if.rx_done, rx_if.frame_err, rx_if.break_det} !== 3'b000) begin err_cnt++; $display("FAIL reset_pulses: got %b exp 000", {rx_if.rx_done, rx_if.frame_err, rx_if.break_det}); end
        vec_cnt++; if (rx_if.rx_busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b exp 0", rx_if.rx_busy); end
        reset = 1'b1;
        wait_cyc(2 * BIT);
    endtask

    task automatic test_good_frame;
        int d0, f0, b0;
        d0 = done_cnt; f0 = ferr_cnt; b0 = brk_cnt;
        send_frame(8'h55, 1'b1, 1'b1, 1'b0);
        wait_cyc(BIT);
        vec_cnt++; if (done_cnt - d0 !== 1) begin err_cnt++; $display("FAIL good_done_cnt: got %0d exp 1", done_cnt - d0); end
        vec_cnt++; if (rx_if.rx_dout !== 8'h55) begin err_cnt++; $display("FAIL good_dout: got %h exp 55", rx_if.rx_dout); end
        vec_cnt++; if ((ferr_cnt - f0) + (brk_cnt - b0) !== 0) begin err_cnt++; $display("FAIL good_errs: got %0d exp 0", (ferr_cnt - f0) + (brk_cnt - b0)); end
    endtask

    task automatic test_glitch;
        int p0;
        p0 = done_cnt + ferr_cnt + brk_cnt;
        rx = 1'b0;
        wait_cyc(4 * CD);
        rx = 1'b1;
        wait_cyc(2);
        vec_cnt++; if (rx_if.rx_busy !== 1'b1) begin err_cnt++; $display("FAIL glitch_busy_start: got %b exp 1", rx_if.rx_busy); end
        wait_cyc(12 * CD);
        vec_cnt++; if (rx_if.rx_busy !== 1'b0) begin err_cnt++; $display("FAIL glitch_busy_end: got %b exp 0", rx_if.rx_busy); end
        wait_cyc(2 * BIT);
        vec_cnt++; if (done_cnt + ferr_cnt + brk_cnt - p0 !== 0) begin err_cnt++; $display("FAIL glitch_pulses: got %0d exp 0", done_cnt + ferr_cnt + brk_cnt - p0); end
        vec_cnt++; if (rx_if.rx_dout !== 8'h55) begin err_cnt++; $display("FAIL glitch_dout: got %h exp 55", rx_if.rx_dout); end
    endtask

    task automatic test_frame_err;
        int d0, f0, b0;
        d0 = done_cnt; f0 = ferr_cnt; b0 = brk_cnt;
        send_frame(8'hA3, 1'b1, 1'b0, 1'b0);
        wait_cyc(2 * BIT);
        vec_cnt++; if (ferr_cnt - f0 !== 1) begin err_cnt++; $display("FAIL ferr_cnt: got %0d exp 1", ferr_cnt - f0); end
        vec_cnt++; if ((done_cnt - d0) + (brk_cnt - b0) !== 0) begin err_cnt++; $display("FAIL ferr_other: got %0d exp 0", (done_cnt - d0) + (brk_cnt - b0)); end
        vec_cnt++; if (rx_if.rx_dout !== 8'h55) begin err_cnt++; $display("FAIL ferr_dout: got %h exp 55", rx_if.rx_dout); end
    endtask

    task automatic test_break;
        int d0, f0, b0;
        d0 = done_cnt; f0 = ferr_cnt; b0 = brk_cnt;
        rx = 1'b0;
        wait_cyc(12 * BIT);
        vec_cnt++; if (brk_cnt - b0 !== 1) begin err_cnt++; $display("FAIL brk_cnt: got %0d exp 1", brk_cnt - b0); end
        vec_cnt++; if (rx_if.rx_busy !== 1'b1) begin err_cnt++; $display("FAIL brk_wait_busy: got %b exp 1", rx_if.rx_busy); end
        vec_cnt++; if ((done_cnt - d0) + (ferr_cnt - f0) !== 0) begin err_cnt++; $display("FAIL brk_other: got %0d exp 0", (done_cnt - d0) + (ferr_cnt - f0)); end
        rx = 1'b1;
        wait_cyc(6);
        vec_cnt++; if (rx_if.rx_busy !== 1'b0) begin err_cnt++; $display("FAIL brk_release_busy: got %b exp 0", rx_if.rx_busy); end
        wait_cyc(2 * BIT);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        wait_cyc(BIT);
        vec_cnt++; if (brk_cnt - b0 !== 1) begin err_cnt++; $display("FAIL brk_single: got %0d exp 1", brk_cnt - b0); end
        vec_cnt++; if (done_cnt - d0 !== 1) begin err_cnt++; $display("FAIL brk_next_done: got %0d exp 1", done_cnt - d0); end
        vec_cnt++; if (rx_if.rx_dout !== 8'h3C) begin err_cnt++; $display("FAIL brk_next_dout: got %h exp 3c", rx_if.rx_dout); end
    endtask

    task automatic test_majority;
        int d0;
        d0 = done_cnt;
        send_frame(8'h96, 1'b1, 1'b1, 1'b1);
        wait_cyc(BIT);
        vec_cnt++; if (done_cnt - d0 !== 1) begin err_cnt++; $display("FAIL maj_done: got %0d exp 1", done_cnt - d0); end
        vec_cnt++; if (rx_if.rx_dout !== 8'h96) begin err_cnt++; $display("FAIL maj_dout: got %h exp 96", rx_if.rx_dout); end
    endtask

    task automatic test_back_to_back;
        int d0, q0;
        logic [NB-1:0] exp_w [3];
        exp_w[0] = 8'h01; exp_w[1] = 8'h80; exp_w[2] = 8'hFF;
        d0 = done_cnt;
        q0 = got_q.size();
        for (int i = 0; i < 3; i++) send_frame(exp_w[i], 1'b1, 1'b1, 1'b0);
        wait_cyc(BIT);
        vec_cnt++; if (done_cnt - d0 !== 3) begin err_cnt++; $display("FAIL b2b_done: got %0d exp 3", done_cnt - d0); end
        for (int i = 0; i < 3; i++) begin
            vec_cnt++;
            if (got_q.size() <= q0 + i) begin
                err_cnt++; $display("FAIL b2b_word%0d: got none exp %h", i, exp_w[i]);
            end else if (got_q[q0 + i] !== exp_w[i]) begin
                err_cnt++; $display("FAIL b2b_word%0d: got %h exp %h", i, got_q[q0 + i], exp_w[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int p0;
        p0 = done_cnt + ferr_cnt + brk_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        rx = 1'b0;
        wait_cyc(BIT / 2);
        vec_cnt++; if (rx_if.rx_busy !== 1'b1) begin err_cnt++; $display("FAIL mid_busy_pre: got %b exp 1", rx_if.rx_busy); end
        #2 reset = 1'b0;
        #1;
        vec_cnt++; if (rx_if.rx_dout !== 8'h00) begin err_cnt++; $display("FAIL mid_dout: got %h exp 00", rx_if.rx_dout); end
        vec_cnt++; if ({rx_if.rx_busy, rx_if.rx_done, rx_if.frame_err, rx_if.break_det} !== 4'b0000) begin err_cnt++; $display("FAIL mid_outs: got %b exp 0000", {rx_if.rx_busy, rx_if.rx_done, rx_if.frame_err, rx_if.break_det}); end
        rx = 1'b1;
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(20 * BIT);
        vec_cnt++; if (done_cnt + ferr_cnt + brk_cnt - p0 !== 0) begin err_cnt++; $display("FAIL mid_no_pulse: got %0d exp 0", done_cnt + ferr_cnt + brk_cnt - p0); end
        vec_cnt++; if ({rx_if.rx_busy, rx_if.rx_dout} !== 9'h000) begin err_cnt++; $display("FAIL mid_after: got %h exp 000", {rx_if.rx_busy, rx_if.rx_dout}); end
    endtask

    task automatic test_pulse_shape;
        vec_cnt++; if (excl_cnt !== 0) begin err_cnt++; $display("FAIL pulse_exclusive: got %0d exp 0", excl_cnt); end
        vec_cnt++; if (wide_cnt !== 0) begin err_cnt++; $display("FAIL pulse_width: got %0d exp 0", wide_cnt); end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_glitch;
        test_frame_err;
        test_break;
        test_majority;
        test_back_to_back;
        test_reset_mid;
        test_pulse_shape;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- 16x-oversampling UART receiver with a built-in baud-tick generator, majority-vote bit sampling, framing-error and break detection.
- Drives the receive-FIFO write side directly: rx_dout to wr_data, rx_done to wr_en.
- Drop-in sibling of the existing transmitter: same frame format (1 start, nbits data LSB-first, stpbits stop, no parity).

Parameters:
- nbits, 8, data bits per frame (5..9)
- stpbits, 2, stop bits per frame (1 or 2)
- clk_div, 54, clk cycles per oversample tick (>=2; 54 = 115200 baud at 100 MHz)

Ports:
- clk  input  1  system clock, all logic rising-edge
- reset  input  1  asynchronous, active-low reset
- rx  input  1  serial line, idle high, asynchronous to clk
- rx_dout  output  nbits  last good received word
- rx_done  output  1  one-cycle pulse, rx_dout valid
- frame_err  output  1  one-cycle pulse, a stop bit sampled 0
- break_det  output  1  one-cycle pulse, break condition detected
- rx_busy  output  1  high in any state except IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; synchronizer flops=1; tick counter, sample counter s_cnt, bit counter n = 0; rx_dout=0; all pulses 0.
- rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s. Two cycles of input latency.
- Tick generator: counts 0..clk_div-1 and pulses tick when the count equals clk_div-1. Forced to 0 on the IDLE->START transition so sampling is phase-aligned to the falling edge.
- s_cnt advances 0..15 on tick. Samples at s_cnt 7, 8, 9 are stored; bit value = majority of the three.
- IDLE: rx_s==0 -> START, s_cnt=0.
- START:
  - at tick s_cnt==8: if majority(7,8,9) is not yet complete, use the 7/8 samples. If both are 1 -> IDLE (glitch rejected), no output.
  - at s_cnt==15 tick: if majority==0 -> DATA, n=0; else -> IDLE.
- DATA:
  - at s_cnt==15 tick: shift majority into MSB of the shift register (LSB-first reception), n++.
  - after bit nbits-1 -> STOP, n=0.
- STOP:
  - each stop bit evaluated at s_cnt==9 tick (majority complete).
  - Non-final stop bit: continue to s_cnt==15, n++.
  - Final stop bit, evaluated at s_cnt==9 (early exit for resync):
    - all stop bits 1 -> rx_dout<=shift reg, rx_done=1 for one clk, -> IDLE.
    - any stop bit 0 and shift reg all-zero -> break_det=1 for one clk, -> BRK_WAIT.
    - any stop bit 0 otherwise -> frame_err=1 for one clk, rx_dout unchanged, -> IDLE.
- BRK_WAIT: rx_s==1 -> IDLE. No frames are accepted while the line stays low.
- rx_done, frame_err and break_det are mutually exclusive; at most one pulse per frame.
- rx_dout holds its value between good frames. It is never updated on an error.
- A falling edge arriving on the cycle IDLE is re-entered is accepted, so back-to-back frames are received with no gap.
- Reset asserted mid-frame aborts immediately. The partial frame is discarded with no pulse.

Decomposition:
- Shared package/include uart_defs:
  - state encodings IDLE, START, DATA, STOP, BRK_WAIT
  - OS_RATE=16
  - SMP_LO=7, SMP_MID=8, SMP_HI=9
  - these are reused by the transmitter when it moves to oversampled timing.
- One sub-module: uart_baud_tick (clk, reset, clr, tick; parameter clk_div). It is shared with the transmitter.

Test Plan:
- nbits=8, stpbits=2, frame 0x55 at nominal baud -> rx_done one clk, rx_dout=0x55, frame_err=0, break_det=0.
- 4-tick low glitch on idle line -> no pulse, rx_busy returns 0 by tick 16, rx_dout unchanged.
- Frame 0xA3 with second stop bit driven 0 -> frame_err one clk, no rx_done, rx_dout keeps prior 0x55.
- Line held low 12 bit times, then high -> single break_det pulse; idle until high; a following frame 0x3C is received correctly.
- 0x96 with a 1-tick inverted pulse at s_cnt 8 of every data bit -> majority yields rx_dout=0x96, rx_done.
- Three back-to-back frames 0x01, 0x80, 0xFF with no idle gap -> three rx_done pulses in order. Separately: reset low mid-DATA -> all outputs 0, state IDLE, no pulse after release.
